// File: rtl/stream_pkg.sv
// Shared definitions for the 1-bit crypto stream link (serializer and parser side).
package stream_pkg;

    localparam int STREAM_WIDTH = 128;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [STREAM_WIDTH-1:0] KEY_TEST = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

endpackage

// File: rtl/stream_serializer.sv
// MSB-first serializer for the crypto stream link; end_of_sequence marks the final frame bit.
// Optional trailing even-parity bit enabled by defining STREAM_SER_PARITY_EN.
module stream_serializer
    import stream_pkg::*;
#(
    parameter int WIDTH      = STREAM_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_block,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             abort,
    output logic             out_data,
    output logic             out_valid,
    output logic             end_of_sequence,
    output logic             busy
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam state_e        DONE_ST  = (GAP_CYCLES > 0) ? GAP : IDLE;
    localparam logic [7:0]    GAP_INIT = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    bit_cnt;
    logic [7:0]       gap_cnt;
    logic             accept;
    logic             frame_end;

    // abort outranks a same-cycle accept
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready && !abort;
    assign busy     = (state != IDLE);

`ifdef STREAM_SER_PARITY_EN
    logic par;
    logic par_phase;
    assign frame_end = par_phase;
`else
    assign frame_end = (bit_cnt == LAST);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            shreg           <= '0;
            bit_cnt         <= '0;
            gap_cnt         <= '0;
            out_data        <= 1'b0;
            out_valid       <= 1'b0;
            end_of_sequence <= 1'b0;
`ifdef STREAM_SER_PARITY_EN
            par             <= 1'b0;
            par_phase       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state           <= SHIFT;
                        shreg           <= in_block << 1;
                        out_data        <= in_block[WIDTH-1];
                        out_valid       <= 1'b1;
                        end_of_sequence <= 1'b0;
                        bit_cnt         <= '0;
`ifdef STREAM_SER_PARITY_EN
                        par             <= ^in_block;
                        par_phase       <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    if (abort || frame_end) begin
                        state           <= DONE_ST;
                        gap_cnt         <= GAP_INIT;
                        out_data        <= 1'b0;
                        out_valid       <= 1'b0;
                        end_of_sequence <= 1'b0;
                        bit_cnt         <= '0;
`ifdef STREAM_SER_PARITY_EN
                        par_phase       <= 1'b0;
                    end else if (bit_cnt == LAST) begin
                        out_data        <= par;
                        end_of_sequence <= 1'b1;
                        par_phase       <= 1'b1;
                    end else begin
                        out_data        <= shreg[WIDTH-1];
                        shreg           <= shreg << 1;
                        bit_cnt         <= bit_cnt + 1'b1;
                        end_of_sequence <= 1'b0;
                    end
`else
                    end else begin
                        out_data        <= shreg[WIDTH-1];
                        shreg           <= shreg << 1;
                        bit_cnt         <= bit_cnt + 1'b1;
                        end_of_sequence <= (bit_cnt == LAST - 1'b1);
                    end
`endif
                end
                GAP: begin
                    if (gap_cnt == 8'd0) state <= IDLE;
                    else                 gap_cnt <= gap_cnt - 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_serializer.sv
// Directed bench for stream_serializer: two instances (GAP_CYCLES 0 and 3) with a bit-level parser model.
module tb_stream_serializer;
    import stream_pkg::*;

    localparam int W = STREAM_WIDTH;
`ifdef STREAM_SER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] in_block  [2];
    logic         in_valid  [2];
    logic         abort     [2];
    logic         in_ready  [2];
    logic         out_data  [2];
    logic         out_valid [2];
    logic         eos       [2];
    logic         busy      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_serializer #(.WIDTH(W), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .in_block(in_block[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .abort(abort[0]), .out_data(out_data[0]),
        .out_valid(out_valid[0]), .end_of_sequence(eos[0]), .busy(busy[0])
    );

    stream_serializer #(.WIDTH(W), .GAP_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .in_block(in_block[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .abort(abort[1]), .out_data(out_data[1]),
        .out_valid(out_valid[1]), .end_of_sequence(eos[1]), .busy(busy[1])
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Parser view of a good frame: data bits then (optionally) the even-parity bit.
    function automatic logic [W:0] expw(input logic [W-1:0] b);
`ifdef STREAM_SER_PARITY_EN
        return {b, ^b};
`else
        return {1'b0, b};
`endif
    endfunction

    // Offer one block, then shift every out_valid bit into a parser-style register.
    // kill_at >= 0 asserts abort (or rst when kill_rst) during that bit's cycle.
    task automatic xfer(input int d, input logic [W-1:0] blk, input int kill_at, input bit kill_rst,
                        output logic [W:0] word, output int nbits, output int eos_n, output int eos_idx);
        int t;
        word = '0; nbits = 0; eos_n = 0; eos_idx = -1; t = 0;
        in_block[d] = blk;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && t < 400) begin tick; t++; end
        chk("accept_wait", t < 400, 1);
        tick;
        in_valid[d] = 1'b0;
        t = 0;
        while (out_valid[d] && t < 400) begin
            word = {word[W-1:0], out_data[d]};
            if (eos[d]) begin eos_n++; eos_idx = nbits; end
            nbits++;
            if (nbits - 1 == kill_at) begin
                if (kill_rst) rst = 1'b1;
                else          abort[d] = 1'b1;
            end
            tick;
            abort[d] = 1'b0;
            t++;
        end
        chk("data_when_idle", out_data[d], 0);
        chk("eos_when_idle", eos[d], 0);
        if (kill_rst) begin
            chk("busy_after_rst", busy[d], 0);
            chk("ready_in_rst", in_ready[d], 0);
            rst = 1'b0;
        end
    endtask

    // Hold in_valid across two blocks (all ones, then zero) and measure the idle spacing.
    task automatic b2b(input int d, input int exp_idle);
        int n1, n2, ones1, ones2, idle, t;
        n1 = 0; n2 = 0; ones1 = 0; ones2 = 0; idle = 0; t = 0;
        in_block[d] = '1;
        in_valid[d] = 1'b1;
        while (!in_ready[d] && t < 400) begin tick; t++; end
        tick;
        in_block[d] = '0;
        while (out_valid[d] && t < 1000) begin n1++; ones1 += int'(out_data[d]); tick; t++; end
        while (!out_valid[d] && t < 1000) begin idle++; tick; t++; end
        in_valid[d] = 1'b0;
        while (out_valid[d] && t < 1000) begin n2++; ones2 += int'(out_data[d]); tick; t++; end
        chk($sformatf("b2b%0d_len1", d), n1, FRAME);
        chk($sformatf("b2b%0d_ones1", d), ones1, W);
        chk($sformatf("b2b%0d_idle", d), idle, exp_idle);
        chk($sformatf("b2b%0d_len2", d), n2, FRAME);
        chk($sformatf("b2b%0d_ones2", d), ones2, 0);
    endtask

    initial begin
        logic [W:0]   word;
        logic [W-1:0] blk;
        int nbits, eos_n, eos_idx;

        for (int i = 0; i < 2; i++) begin
            in_block[i] = '0; in_valid[i] = 1'b0; abort[i] = 1'b0;
        end

        // reset held 3 cycles with a block on offer
        in_block[0] = KEY_TEST;
        in_valid[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("rst_valid", out_valid[0], 0);
            chk("rst_data", out_data[0], 0);
            chk("rst_eos", eos[0], 0);
            chk("rst_busy", busy[0], 0);
            chk("rst_ready", in_ready[0], 0);
        end
        rst = 1'b0;
        in_valid[0] = 1'b0;
        #1;
        chk("ready_after_rst", in_ready[0], 1);
        tick;
        chk("no_accept_in_rst", busy[0], 0);

        // single frame into the parser model
        xfer(0, KEY_TEST, -1, 1'b0, word, nbits, eos_n, eos_idx);
        chk("key_word", word, expw(KEY_TEST));
        chk("key_len", nbits, FRAME);
        chk("key_eos_cnt", eos_n, 1);
        chk("key_eos_pos", eos_idx, FRAME - 1);
        chk("key_first_bit", word[FRAME-1], 0);
        chk("key_last_bit", word[PAR], 0);

        // back-to-back spacing
        b2b(0, 1);
        b2b(1, 4);

        // abort during bit 40, then an intact frame
        xfer(0, KEY_TEST, 40, 1'b0, word, nbits, eos_n, eos_idx);
        chk("abort_len", nbits, 41);
        chk("abort_eos", eos_n, 0);
        blk = 128'hDEAD_BEEF_0000_FFFF_1234_5678_9ABC_DEF0;
        xfer(0, blk, -1, 1'b0, word, nbits, eos_n, eos_idx);
        chk("post_abort_word", word, expw(blk));
        chk("post_abort_eos", eos_idx, FRAME - 1);

        // abort on the GAP instance leaves it in GAP for its full count
        xfer(1, KEY_TEST, 10, 1'b0, word, nbits, eos_n, eos_idx);
        chk("abort3_len", nbits, 11);
        chk("abort3_gap_busy", busy[1], 1);

        // reset mid-frame at bit 100, then alternating pattern
        xfer(0, KEY_TEST, 100, 1'b1, word, nbits, eos_n, eos_idx);
        chk("rst_mid_len", nbits, 101);
        chk("rst_mid_eos", eos_n, 0);
        blk = {16{8'hA5}};
        xfer(0, blk, -1, 1'b0, word, nbits, eos_n, eos_idx);
        chk("a5_word", word, expw(blk));
        chk("a5_head", word[FRAME-1 -: 4], 4'b1010);
        chk("a5_len", nbits, FRAME);

`ifdef STREAM_SER_PARITY_EN
        blk = 128'h1;
        xfer(0, blk, -1, 1'b0, word, nbits, eos_n, eos_idx);
        chk("par1_word", word, {128'h1, 1'b1});
        chk("par1_eos", eos_idx, 128);
        chk("par1_len", nbits, 129);
        blk = 128'h3;
        xfer(0, blk, -1, 1'b0, word, nbits, eos_n, eos_idx);
        chk("par3_word", word, {128'h3, 1'b0});
        chk("par3_eos", eos_idx, 128);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
